// File: rtl/wb_ahb_pkg.sv
// Shared types and AHB encodings for the Wishbone-to-AHB arbiter slice.
package wb_ahb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ADDR  = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_ERROR = 4'b1000
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/wb_ahb_rr_arbiter.sv
// Round-robin pointer and one-hot winner selection for the Wishbone masters.
module wb_ahb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   update,
  input  logic [NUM_MASTERS-1:0] owner,
  output logic [NUM_MASTERS-1:0] winner
);

  localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] owner_idx;

  // Search begins one past the last completed owner and wraps.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      idx = PW'((32'(ptr) + off) % NUM_MASTERS);
      if (winner == '0 && req[idx]) winner[idx] = 1'b1;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (owner[i]) owner_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= PW'(NUM_MASTERS - 1);
    else if (update) ptr <= owner_idx;
  end

endmodule

// File: rtl/wb_ahb_arbiter.sv
// Multi-master Wishbone to single AHB-Lite master bridge with round-robin arbitration.
// Optional bus locking is enabled by defining WB_AHB_ARB_LOCK_EN.
module wb_ahb_arbiter
  import wb_ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic                      ahb_hclk,
  input  logic                      ahb_hreset,
  input  logic [NUM_MASTERS-1:0]    wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wb_stb_i,
  input  logic [NUM_MASTERS-1:0]    wb_we_i,
  input  logic [NUM_MASTERS*AW-1:0] wb_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] wb_dat_i,
`ifdef WB_AHB_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]    wb_lock_i,
  output logic                      ahb_hmastlock,
`endif
  output logic [NUM_MASTERS-1:0]    wb_ack_o,
  output logic [NUM_MASTERS-1:0]    wb_err_o,
  output logic [DW-1:0]             wb_dat_o,
  output logic [AW-1:0]             ahb_haddr,
  output logic [1:0]                ahb_htrans,
  output logic                      ahb_hwrite,
  output logic [2:0]                ahb_hsize,
  output logic [DW-1:0]             ahb_hwdata,
  input  logic [DW-1:0]             ahb_hrdata,
  input  logic                      ahb_hready,
  input  logic                      ahb_hresp,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      fsm_error
);

  arb_state_e             state, state_n;
  logic [NUM_MASTERS-1:0] req, winner, grant_n;
  logic [AW-1:0]          haddr_q, addr_sel;
  logic                   hwrite_q, we_sel;
  logic [DW-1:0]          wdat_sel;
  logic                   load_addr, rr_update, keep_owner, lock_hold, data_done;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_AHB_ARB_LOCK_EN
  assign lock_hold     = |(grant_o & wb_lock_i);
  assign ahb_hmastlock = (state == ST_ADDR) && lock_hold;
`else
  assign lock_hold = 1'b0;
`endif

  // grant_o can only be non-zero in IDLE when a locked owner kept it.
  assign keep_owner = |(grant_o & req);

  wb_ahb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .clk    (ahb_hclk),
    .rst_n  (ahb_hreset),
    .req    (req),
    .update (rr_update),
    .owner  (grant_o),
    .winner (winner)
  );

  always_comb begin
    state_n   = state;
    grant_n   = grant_o;
    load_addr = 1'b0;
    rr_update = 1'b0;
    case (state)
      ST_IDLE: begin
        if (keep_owner) begin
          state_n   = ST_ADDR;
          load_addr = 1'b1;
        end else if (|req) begin
          state_n   = ST_ADDR;
          grant_n   = winner;
          load_addr = 1'b1;
        end else begin
          grant_n = '0;
        end
      end
      ST_ADDR: if (ahb_hready) state_n = ST_DATA;
      ST_DATA: begin
        if (ahb_hready) begin
          state_n   = ST_IDLE;
          rr_update = 1'b1;
          grant_n   = lock_hold ? grant_o : '0;
        end
      end
      ST_ERROR: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = ST_ERROR;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    addr_sel = '0;
    we_sel   = 1'b0;
    wdat_sel = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_n[i]) begin
        addr_sel = wb_adr_i[i*AW +: AW];
        we_sel   = wb_we_i[i];
      end
      if (grant_o[i]) wdat_sel = wb_dat_i[i*DW +: DW];
    end
  end

  // Address phase is captured at arbitration so it stays stable across wait states.
  always_ff @(posedge ahb_hclk or negedge ahb_hreset) begin
    if (!ahb_hreset) begin
      state    <= ST_IDLE;
      grant_o  <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
    end else begin
      state   <= state_n;
      grant_o <= grant_n;
      if (load_addr) begin
        haddr_q  <= addr_sel;
        hwrite_q <= we_sel;
      end
    end
  end

  assign data_done  = (state == ST_DATA) && ahb_hready;
  assign wb_ack_o   = {NUM_MASTERS{data_done && (ahb_hresp == HRESP_OKAY)}} & grant_o & wb_cyc_i;
  assign wb_err_o   = {NUM_MASTERS{data_done && (ahb_hresp == HRESP_ERROR)}} & grant_o & wb_cyc_i;
  assign wb_dat_o   = ahb_hrdata;
  assign ahb_htrans = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_haddr  = haddr_q;
  assign ahb_hwrite = hwrite_q;
  assign ahb_hsize  = HSIZE_WORD;
  assign ahb_hwdata = wdat_sel;
  assign fsm_error  = (state == ST_ERROR);

endmodule

// File: tb/tb_wb_ahb_arbiter.sv
// Scoreboard bench for wb_ahb_arbiter (two masters); lock scenario when WB_AHB_ARB_LOCK_EN is defined.
module tb_wb_ahb_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  wb_cyc, wb_stb, wb_we;
  logic [N*32-1:0] wb_adr, wb_dat;
  logic [N-1:0]  wb_ack, wb_err;
  logic [31:0]   wb_rdat;
  logic [31:0]   haddr, hwdata, hrdata;
  logic [1:0]    htrans;
  logic          hwrite, hready, hresp, fsm_error;
  logic [2:0]    hsize;
  logic [N-1:0]  grant;
`ifdef WB_AHB_ARB_LOCK_EN
  logic [N-1:0]  wb_lock;
  logic          hmastlock;
`endif

  typedef struct {
    int          m;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   model_ptr;

  always #5 clk = ~clk;

  wb_ahb_arbiter #(.NUM_MASTERS(N), .AW(32), .DW(32)) dut (
    .ahb_hclk   (clk),
    .ahb_hreset (rst_n),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat),
`ifdef WB_AHB_ARB_LOCK_EN
    .wb_lock_i     (wb_lock),
    .ahb_hmastlock (hmastlock),
`endif
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .wb_dat_o   (wb_rdat),
    .ahb_haddr  (haddr),
    .ahb_htrans (htrans),
    .ahb_hwrite (hwrite),
    .ahb_hsize  (hsize),
    .ahb_hwdata (hwdata),
    .ahb_hrdata (hrdata),
    .ahb_hready (hready),
    .ahb_hresp  (hresp),
    .grant_o    (grant),
    .fsm_error  (fsm_error)
  );

  // Termination monitor: every ack/err must match the oldest expected transfer.
  always @(negedge clk) begin
    if ((|wb_ack) || (|wb_err)) begin
      exp_t e;
      logic [N-1:0] ea, ee;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL term_unexpected: ack=%b err=%b, required no termination", wb_ack, wb_err);
      end else begin
        e  = sb.pop_front();
        ea = '0;
        ee = '0;
        if (e.err) ee[e.m] = 1'b1;
        else       ea[e.m] = 1'b1;
        if (wb_ack !== ea || wb_err !== ee) begin
          errors++;
          $display("FAIL term_match: ack=%b err=%b, required ack=%b err=%b", wb_ack, wb_err, ea, ee);
        end
        if (e.chk_rd) begin
          checks++;
          if (wb_rdat !== e.rd) begin
            errors++;
            $display("FAIL read_data: got %h, required %h", wb_rdat, e.rd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc[m] = cyc;
    wb_stb[m] = cyc;
    wb_we[m]  = we;
    wb_adr[m*32 +: 32] = adr;
    wb_dat[m*32 +: 32] = dat;
  endtask

  task automatic drop_all;
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
`ifdef WB_AHB_ARB_LOCK_EN
    wb_lock = '0;
`endif
    wb_cyc = '0; wb_stb = '0; wb_we = '0; wb_adr = '0; wb_dat = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({htrans, grant, haddr, hwrite, wb_ack, wb_err, fsm_error, hsize} !==
        {2'b00, 2'b00, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010}) begin
      errors++;
      $display("FAIL reset_state: htrans=%b grant=%b haddr=%h hwrite=%b ack=%b err=%b fsm_err=%b hsize=%b, required 00 00 0 0 00 00 0 010",
               htrans, grant, haddr, hwrite, wb_ack, wb_err, fsm_error, hsize);
    end
    rst_n = 1'b1;
    model_ptr = N - 1;
    tick;
  endtask

  task automatic test_single_write;
    set_master(0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    sb.push_back('{0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00) begin errors++; $display("FAIL wr_c1_htrans: got %b, required 00", htrans); end
    tick; @(negedge clk);
    checks++;
    if ({htrans, haddr, hwrite, grant} !== {2'b10, 32'h100, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL wr_c2_addr: htrans=%b haddr=%h hwrite=%b grant=%b, required 10 00000100 1 01", htrans, haddr, hwrite, grant);
    end
    tick; @(negedge clk);
    checks++;
    if ({htrans, hwdata, wb_ack} !== {2'b00, 32'hDEADBEEF, 2'b01}) begin
      errors++;
      $display("FAIL wr_c3_data: htrans=%b hwdata=%h ack=%b, required 00 deadbeef 01", htrans, hwdata, wb_ack);
    end
    tick;
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (wb_ack !== 2'b00) begin errors++; $display("FAIL wr_ack_width: ack=%b, required 00", wb_ack); end
    model_ptr = 0;
    tick;
  endtask

  task automatic test_round_robin;
    int e;
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_master(1, 1'b1, 1'b1, 32'h20, 32'hB1);
    for (int k = 0; k < 4; k++) begin
      e = (model_ptr + 1) % N;
      sb.push_back('{e, 1'b0, 1'b0, 32'h0});
      @(negedge clk);
      tick; @(negedge clk);
      checks++;
      if (grant !== 2'(1 << e) || haddr !== 32'((e + 1) * 16)) begin
        errors++;
        $display("FAIL rr_grant_%0d: grant=%b haddr=%h, required grant for master %0d", k, grant, haddr, e);
      end
      tick; @(negedge clk);
      model_ptr = e;
      tick;
    end
    drop_all;
  endtask

  task automatic test_read_wait;
    set_master(1, 1'b1, 1'b0, 32'h200, 32'h0);
    sb.push_back('{1, 1'b0, 1'b1, 32'h12345678});
    @(negedge clk);
    tick; hready = 1'b0; @(negedge clk);
    tick; hready = 1'b1; @(negedge clk);
    checks++;
    if ({htrans, haddr, hwrite} !== {2'b10, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL rd_addr_hold: htrans=%b haddr=%h hwrite=%b, required 10 00000200 0", htrans, haddr, hwrite);
    end
    for (int w = 0; w < 2; w++) begin
      tick; hready = 1'b0; @(negedge clk);
      checks++;
      if ({htrans, grant, wb_ack} !== {2'b00, 2'b10, 2'b00}) begin
        errors++;
        $display("FAIL rd_wait_%0d: htrans=%b grant=%b ack=%b, required 00 10 00", w, htrans, grant, wb_ack);
      end
    end
    tick; hready = 1'b1; hrdata = 32'h12345678; @(negedge clk);
    tick; drop_all; hrdata = '0;
    model_ptr = 1;
  endtask

  task automatic test_error;
    set_master(1, 1'b1, 1'b1, 32'h300, 32'h55);
    sb.push_back('{1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    tick; @(negedge clk);
    tick; hready = 1'b0; hresp = 1'b1; @(negedge clk);
    checks++;
    if ({wb_err, wb_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL err_first_cycle: err=%b ack=%b, required 00 00", wb_err, wb_ack);
    end
    tick; hready = 1'b1; @(negedge clk);
    checks++;
    if ({wb_err, wb_ack} !== {2'b10, 2'b00}) begin
      errors++;
      $display("FAIL err_second_cycle: err=%b ack=%b, required 10 00", wb_err, wb_ack);
    end
    tick; hresp = 1'b0; drop_all;
    model_ptr = 1;
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_master(1, 1'b1, 1'b1, 32'h20, 32'hB1);
    sb.push_back('{0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    tick; @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL err_ptr_advance: grant=%b, required 01", grant); end
    tick; @(negedge clk);
    tick; drop_all;
    model_ptr = 0;
  endtask

  task automatic test_masked;
    set_master(1, 1'b1, 1'b1, 32'h400, 32'h66);
    @(negedge clk);
    tick; set_master(1, 1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk);
    checks++;
    if ({htrans, haddr, grant} !== {2'b10, 32'h400, 2'b10}) begin
      errors++;
      $display("FAIL mask_addr: htrans=%b haddr=%h grant=%b, required 10 00000400 10", htrans, haddr, grant);
    end
    tick; @(negedge clk);
    checks++;
    if ({htrans, wb_ack, wb_err} !== 6'b000000) begin
      errors++;
      $display("FAIL mask_term: htrans=%b ack=%b err=%b, required 00 00 00", htrans, wb_ack, wb_err);
    end
    tick;
    model_ptr = 1;
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_master(1, 1'b1, 1'b1, 32'h20, 32'hB1);
    sb.push_back('{0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    tick; @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL mask_ptr_advance: grant=%b, required 01", grant); end
    tick; @(negedge clk);
    tick; drop_all;
    model_ptr = 0;
  endtask

`ifdef WB_AHB_ARB_LOCK_EN
  task automatic test_lock;
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_master(1, 1'b1, 1'b1, 32'h20, 32'hB1);
    wb_lock = 2'b10;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1, 1'b0, 1'b0, 32'h0});
      @(negedge clk);
      tick; @(negedge clk);
      checks++;
      if (grant !== 2'b10 || hmastlock !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold_%0d: grant=%b hmastlock=%b, required 10 1", k, grant, hmastlock);
      end
      tick; @(negedge clk);
      tick;
    end
    drop_all;
    wb_lock = '0;
    tick;
    model_ptr = 1;
  endtask
`endif

  task automatic test_reset_mid;
    set_master(0, 1'b1, 1'b1, 32'h500, 32'h77);
    @(negedge clk);
    tick; @(negedge clk);
    tick; hready = 1'b0; @(negedge clk);
    checks++;
    if ({htrans, grant} !== {2'b00, 2'b01}) begin
      errors++;
      $display("FAIL rstmid_in_data: htrans=%b grant=%b, required 00 01", htrans, grant);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({htrans, grant, haddr, hwrite, wb_ack, wb_err, fsm_error} !==
        {2'b00, 2'b00, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_outputs: htrans=%b grant=%b haddr=%h hwrite=%b ack=%b err=%b fsm_err=%b, required all zero",
               htrans, grant, haddr, hwrite, wb_ack, wb_err, fsm_error);
    end
    hready = 1'b1;
    drop_all;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    model_ptr = N - 1;
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_master(1, 1'b1, 1'b1, 32'h20, 32'hB1);
    sb.push_back('{0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    tick; @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rstmid_ptr_reset: grant=%b, required 01", grant); end
    tick; @(negedge clk);
    tick; drop_all;
    model_ptr = 0;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_read_wait;
    test_error;
    test_masked;
`ifdef WB_AHB_ARB_LOCK_EN
    test_lock;
`endif
    test_reset_mid;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transfers never terminated, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
